// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI transfer sequencer.
//   state_t   : sequencer FSM states
//   cmd_t     : queued transmit request {data, ss}
//   rsp_t     : queued response {data, ss, err}
//   isOneHot  : legal slave-select check
package spi_seq_pkg;

    // Slave-select width carried in the queued command/response words.
    localparam int SS_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [7:0]      data;
        logic [SS_W-1:0] ss;
    } cmd_t;

    typedef struct packed {
        logic [7:0]      data;
        logic [SS_W-1:0] ss;
        logic            err;
    } rsp_t;

    function automatic logic isOneHot(input logic [SS_W-1:0] ss);
        return (ss != '0) && ((ss & (ss - SS_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer_fifo.sv
// Synchronous FIFO with synchronous active-high reset.
//   clk, rst          : clock, reset
//   push, pushData    : write (ignored when full)
//   pop, popData      : read (ignored when empty), popData shows the head
//   full, empty, count: occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           popData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPush  = push & ~full;
    assign doPop   = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            if (doPush && !doPop)      count <= count + CW'(1);
            else if (!doPush && doPop) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Queued command front-end for the SPI master.
//   Clk_i, Rst_i                      : clock, synchronous active-high reset
//   Req_valid_i/ready_o/data_i/ss_i   : transmit request stream
//   Rsp_valid_o/ready_i/data_o/ss_o/err_o : response stream, in request order
//   Buf_o, Ss_o, Strobe_o             : to master Buf_i, ss_i, Strobe_i
//   MReady_i, MRcvd_i                 : from master Ready_o, Rcvd_o
//   Busy_o                            : FSM not idle
//   Count_o                           : command FIFO occupancy
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | wait for a command and response space, pop the head
// ST_SETUP  | Buf_o/Ss_o settled for one cycle before the strobe
// ST_STROBE | Strobe_o high for this single cycle, arm the timeout
// ST_WAIT   | wait for a MReady_i rising edge or the timeout
// ST_GAP    | GAP idle cycles before the next command
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NSLAVE  = SS_W,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic                       Clk_i,
    input  logic                       Rst_i,
    input  logic                       Req_valid_i,
    output logic                       Req_ready_o,
    input  logic [7:0]                 Req_data_i,
    input  logic [NSLAVE-1:0]          Req_ss_i,
    output logic                       Rsp_valid_o,
    input  logic                       Rsp_ready_i,
    output logic [7:0]                 Rsp_data_o,
    output logic [NSLAVE-1:0]          Rsp_ss_o,
    output logic                       Rsp_err_o,
    output logic [7:0]                 Buf_o,
    output logic [NSLAVE-1:0]          Ss_o,
    output logic                       Strobe_o,
    input  logic                       MReady_i,
    input  logic [7:0]                 MRcvd_i,
    output logic                       Busy_o,
    output logic [$clog2(DEPTH+1)-1:0] Count_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam int GW = $clog2(GAP+1);

    state_t          state, stateNext;
    cmd_t            cmdIn, cmdHead;
    rsp_t            rspIn, rspHead;
    logic            cmdFull, cmdEmpty, cmdPush, cmdPop;
    logic            rspFull, rspEmpty, rspPush, rspPop;
    logic [CW-1:0]   rspCount;
    logic            unusedRspCount;
    logic [7:0]      bufQ;
    logic [NSLAVE-1:0] ssQ;
    logic [TW-1:0]   tcnt, tcntNext;
    logic [GW-1:0]   gcnt, gcntNext;
    logic            mreadyQ;
    logic            mreadyRise;
    logic            loadBuf;

    assign cmdIn       = '{data: Req_data_i, ss: Req_ss_i};
    assign Req_ready_o = ~cmdFull;
    assign cmdPush     = Req_valid_i & ~cmdFull;

    assign Rsp_valid_o = ~rspEmpty;
    assign rspPop      = Rsp_valid_o & Rsp_ready_i;
    // Masked so the stream reads all-zero while empty (FIFO RAM is not reset).
    assign Rsp_data_o  = Rsp_valid_o ? rspHead.data : '0;
    assign Rsp_ss_o    = Rsp_valid_o ? rspHead.ss   : '0;
    assign Rsp_err_o   = Rsp_valid_o & rspHead.err;
    assign unusedRspCount = ^rspCount;

    assign Buf_o      = bufQ;
    assign Ss_o       = ssQ;
    assign Strobe_o   = (state == ST_STROBE);
    assign Busy_o     = (state != ST_IDLE);
    // Only an edge counts: a Ready level already high on WAIT entry is stale.
    assign mreadyRise = MReady_i & ~mreadyQ;

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) uCmdFifo (
        .clk(Clk_i), .rst(Rst_i),
        .push(cmdPush), .pushData(cmdIn),
        .pop(cmdPop), .popData(cmdHead),
        .full(cmdFull), .empty(cmdEmpty), .count(Count_o)
    );

    sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) uRspFifo (
        .clk(Clk_i), .rst(Rst_i),
        .push(rspPush), .pushData(rspIn),
        .pop(rspPop), .popData(rspHead),
        .full(rspFull), .empty(rspEmpty), .count(rspCount)
    );

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state   <= ST_IDLE;
            bufQ    <= '0;
            ssQ     <= '0;
            tcnt    <= '0;
            gcnt    <= '0;
            mreadyQ <= 1'b0;
        end else begin
            state   <= stateNext;
            tcnt    <= tcntNext;
            gcnt    <= gcntNext;
            mreadyQ <= MReady_i;
            if (loadBuf) begin
                bufQ <= cmdHead.data;
                ssQ  <= cmdHead.ss;
            end
        end
    end

    always_comb begin
        stateNext = state;
        tcntNext  = tcnt;
        gcntNext  = gcnt;
        cmdPop    = 1'b0;
        rspPush   = 1'b0;
        rspIn     = '0;
        loadBuf   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // Start only with response space so no response can be lost.
                if (!cmdEmpty && !rspFull) begin
                    cmdPop = 1'b1;
                    if (isOneHot(cmdHead.ss)) begin
                        loadBuf   = 1'b1;
                        stateNext = ST_SETUP;
                    end else begin
                        rspPush   = 1'b1;
                        rspIn     = '{data: 8'h00, ss: cmdHead.ss, err: 1'b1};
                        gcntNext  = GW'(GAP - 1);
                        stateNext = ST_GAP;
                    end
                end
            end
            ST_SETUP: stateNext = ST_STROBE;
            ST_STROBE: begin
                // Timeout is a down-counter: terminal count 0 is the last WAIT cycle.
                tcntNext  = TW'(TIMEOUT - 1);
                stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (mreadyRise) begin
                    rspPush   = 1'b1;
                    rspIn     = '{data: MRcvd_i, ss: ssQ, err: 1'b0};
                    gcntNext  = GW'(GAP - 1);
                    stateNext = ST_GAP;
                end else if (tcnt == '0) begin
                    rspPush   = 1'b1;
                    rspIn     = '{data: 8'h00, ss: ssQ, err: 1'b1};
                    gcntNext  = GW'(GAP - 1);
                    stateNext = ST_GAP;
                end else begin
                    tcntNext = tcnt - TW'(1);
                end
            end
            ST_GAP: begin
                if (gcnt == '0) stateNext = ST_IDLE;
                else            gcntNext  = gcnt - GW'(1);
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
- Queued command front-end that sits directly upstream of the SPI master and drives its Buf/ss/Strobe inputs.
- Buffers transmit requests (byte plus slave select) and issues them to the master one at a time.
- Waits for master receive-complete, or for a timeout, then queues the received byte as a response.
- Replaces ad-hoc strobe generation with a valid/ready stream interface on both sides.

Parameters:
- DEPTH, 8: entries in the command FIFO and in the response FIFO (power of 2, ≥2).
- NSLAVE, 2: slave-select width.
- TIMEOUT, 64: maximum WAIT cycles allowed for master Ready before an error response.
- GAP, 2: minimum idle cycles between consecutive strobes (≥1).

Ports:
- Clk_i  in  1  clock.
- Rst_i  in  1  synchronous reset, active-high.
- Req_valid_i  in  1  request valid.
- Req_ready_o  out  1  command FIFO not full.
- Req_data_i  in  8  byte to transmit.
- Req_ss_i  in  NSLAVE  slave select, must be one-hot.
- Rsp_valid_o  out  1  response FIFO not empty.
- Rsp_ready_i  in  1  response consumed.
- Rsp_data_o  out  8  byte received by master.
- Rsp_ss_o  out  NSLAVE  slave select of the completed transfer.
- Rsp_err_o  out  1  timeout or illegal ss.
- Buf_o  out  8  to master Buf_i.
- Ss_o  out  NSLAVE  to master ss_i.
- Strobe_o  out  1  to master Strobe_i.
- MReady_i  in  1  from master Ready_o.
- MRcvd_i  in  8  from master Rcvd_o.
- Busy_o  out  1  FSM not in IDLE.
- Count_o  out  $clog2(DEPTH+1)  command FIFO occupancy.

Behaviour:
- Reset (synchronous, Rst_i high at a clock edge):
  - Both FIFOs emptied, FSM to IDLE, all counters cleared.
  - All outputs 0, except Req_ready_o=1 in the first cycle after reset.
  - Reset has priority over every other event, including mid-transfer. A late MReady_i after reset is ignored.
- Handshakes:
  - Request accepted when Req_valid_i & Req_ready_o. Req_ready_o = !cmd_full, independent of a same-cycle pop.
  - Response popped when Rsp_valid_o & Rsp_ready_i. Push and pop in the same cycle are legal, count unchanged.
  - Rsp_* outputs come from the FIFO head and are stable while Rsp_valid_o & !Rsp_ready_i.
- MReady edge: mready_q registered every cycle; rise = MReady_i & !mready_q. Only a rise counts as completion, so a level already high on WAIT entry is ignored.
- FSM states: IDLE, SETUP, STROBE, WAIT, GAP.
  - IDLE: if !cmd_empty & !rsp_full, pop the head into Buf_o/Ss_o registers.
    - ss one-hot: go to SETUP.
    - ss not one-hot: push {8'h00, ss, err=1} and go to GAP; Buf_o/Ss_o are not updated.
  - SETUP: one cycle; Buf_o/Ss_o already stable; go to STROBE.
  - STROBE: Strobe_o=1 for exactly this cycle; clear tcnt; go to WAIT.
  - WAIT: tcnt++ each cycle.
    - rise: push {MRcvd_i, Ss_o, 0}, go to GAP.
    - tcnt==TIMEOUT-1 without rise: push {8'h00, Ss_o, 1}, go to GAP.
    - rise wins if both occur in the same cycle.
  - GAP: GAP cycles, then IDLE.
- Buf_o/Ss_o hold their values from SETUP until the next pop.
- Latency: request accepted in cycle N into an empty queue with idle FSM gives pop at N+1, SETUP at N+2, Strobe_o at N+3.
- A transfer starts only if the response FIFO has space, so responses are never dropped.
- Responses are returned strictly in request order.
- Busy_o = (state != IDLE).

Decomposition:
- Package spi_seq_pkg holds:
  - state_t enum.
  - rsp_t struct {data[7:0], ss[NSLAVE-1:0], err}.
  - onehot check function.
- Sub-module sync_fifo #(WIDTH, DEPTH): synchronous, active-high reset, full/empty/count. Instantiated twice, for the command and response FIFOs.

Test Plan:
- Single transfer, data 8'hA5, ss 01:
  - Stimulus: the master model raises Ready 20 cycles after the strobe with Rcvd=8'h3C.
  - Response: Strobe_o is high only at N+3 with Buf_o=A5 and Ss_o=01; the response is {3C, 01, err 0}.
- Ten back-to-back requests with Rsp_ready_i=1:
  - Req_ready_o drops after 8 entries are held.
  - Strobes are issued in order with ≥GAP+2 cycles between them.
  - All 10 responses are returned in order.
- Master never asserts Ready:
  - After 64 WAIT cycles the response is {00, ss, 1}.
  - The next queued transfer then strobes normally.
- Requests with ss=00 and ss=11:
  - No strobe is issued.
  - Two err=1 responses are returned in order, interleaved correctly with a valid request between them.
- Rsp_ready_i held at 0:
  - After 8 responses no further strobe occurs even though commands are queued.
  - Raising Rsp_ready_i drains the responses and resumes transfers.
- MReady_i already high when WAIT is entered: the transfer times out with no false completion.
- Rst_i pulsed during WAIT:
  - Next cycle: Count_o=0, Rsp_valid_o=0, Strobe_o=0.
  - A later MReady rise produces no response.
